// File: rtl/uart_rx_frontend.sv
// UART 8N1 receive front end: two-flop sync, mid-bit framing, one-entry rx_valid/rx_ready output register.
// Latency: rx falling edge to rx_valid = 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles (+CLKS_PER_BIT with parity).
// Backpressure: a held byte is kept while rx_ready=0; a character finishing then is dropped and flagged as overrun.
// Optional even-parity bit after the data bits when UART_RX_PARITY_EN is defined; CLKS_PER_BIT must be >= 4.
module uart_rx_frontend #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int          CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam logic [15:0] BIT_RELOAD   = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_RELOAD  = 16'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] BREAK  = 3'd5;

  logic        rx_s1;
  logic        rs;
  logic [2:0]  state;
  logic [15:0] timer;
  logic [2:0]  idx;
  logic [7:0]  shift;
`ifdef UART_RX_PARITY_EN
  logic        par_bad;
`endif

  // Two-stage synchronizer; both stages idle high so reset never looks like a start bit.
  always_ff @(posedge CLK) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rs    <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rs    <= rx_s1;
    end
  end

  assign rx_busy = (state != IDLE);

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  // Framing FSM plus the output holding register; error pulses line up with the delivery cycle.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= 16'd0;
      idx       <= 3'd0;
      shift     <= 8'd0;
      rx_data   <= 8'd0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      // Consumer handshake; a delivery below in the same cycle overrides this.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rs) begin
            state <= START;
            timer <= HALF_RELOAD;
          end
        end

        START: begin
          if (timer == 16'd0) begin
            // Line back high at mid start bit: a glitch, drop it silently.
            if (!rs) begin
              state <= DATA;
              timer <= BIT_RELOAD;
              idx   <= 3'd0;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end

        DATA: begin
          if (timer == 16'd0) begin
            shift[idx] <= rs;
            timer      <= BIT_RELOAD;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (timer == 16'd0) begin
            // Even parity: data bits plus parity bit must XOR to zero.
            par_bad <= rs ^ (^shift);
            timer   <= BIT_RELOAD;
            state   <= STOP;
          end else begin
            timer <= timer - 16'd1;
          end
        end
`endif

        STOP: begin
          if (timer == 16'd0) begin
`ifdef UART_RX_PARITY_EN
            parity_err <= par_bad;
`endif
            if (rs) begin
              state <= IDLE;
              if (!rx_valid || rx_ready) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end

        BREAK: begin
          // Hold off until the line idles so a long break reports only once.
          if (rs) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
